dm_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the 4 KB data memory (dm_4k).
- Port 0 is the CPU load/store path; port 1 is the program/data loader (debug/DMA).
- Round-robin grant; each access is latched and then driven to the memory for exactly one cycle.
- Each accepted request gets exactly one read-data response.

---
 rtl/dm_arbiter_pkg.sv | 17 +
 rtl/dm_4k.sv | 31 +++
 rtl/rr_arb2.sv | 16 +
 rtl/dm_arbiter.sv | 137 +++++++++++++
 tb/tb_dm_arbiter.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port indices
// and default bus widths.
package dm_arbiter_pkg;

   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 32;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_LDR = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

endpackage

// File: rtl/dm_4k.sv
// 4 KB word-organised data memory with combinational read, synchronous write
// and a store-byte mode that writes only the lane selected by addr[1:0].
module dm_4k (
   input  logic        clk,
   input  logic [11:0] addr,
   input  logic [31:0] din,
   input  logic        WrEn,
   input  logic        storebyte,
   output logic [31:0] dout
);

   logic [31:0] memArray [0:1023];

   always_ff @(posedge clk) begin
      if (WrEn) begin
         if (storebyte) begin
            case (addr[1:0])
               2'd0: memArray[addr[11:2]][7:0]   <= din[7:0];
               2'd1: memArray[addr[11:2]][15:8]  <= din[7:0];
               2'd2: memArray[addr[11:2]][23:16] <= din[7:0];
               default: memArray[addr[11:2]][31:24] <= din[7:0];
            endcase
         end else begin
            memArray[addr[11:2]] <= din;
         end
      end
   end

   assign dout = memArray[addr[11:2]];

endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: on contention the requester that did not win
// last time gets the one-hot grant.
module rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = req_i;
      if (req_i == 2'b11) begin
         gnt_o = last_i ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of dm_4k: each accepted
// request is latched, driven to memory for one ACCESS cycle, then answered.
module dm_arbiter
   import dm_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid0,
   output logic              ready0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              we0,
   input  logic              sb0,
   output logic              rvalid0,
   input  logic              valid1,
   output logic              ready1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   input  logic              we1,
   input  logic              sb1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_wren,
   output logic              mem_sb,
   input  logic [DATA_W-1:0] mem_dout
);

   state_e             state_q;
   logic               lastGrant_q;
   logic               owner_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  wdata_q;
   logic               we_q;
   logic               sb_q;
   logic [DATA_W-1:0]  rdata_q;
   logic               rvalid0_q;
   logic               rvalid1_q;
   logic               busy_q;

   logic [1:0]         gnt;
   logic               owner_d;
   logic [ADDR_W-1:0]  addr_d;
   logic [DATA_W-1:0]  wdata_d;
   logic               we_d;
   logic               sb_d;

   rr_arb2 u_rrArb (
      .req_i  ({valid1, valid0}),
      .last_i (lastGrant_q),
      .gnt_o  (gnt)
   );

   assign ready0 = (state_q == IDLE) && gnt[0];
   assign ready1 = (state_q == IDLE) && gnt[1];

   always_comb begin
      owner_d = PORT_CPU;
      addr_d  = addr0;
      wdata_d = wdata0;
      we_d    = we0;
      sb_d    = sb0;
      if (gnt[1]) begin
         owner_d = PORT_LDR;
         addr_d  = addr1;
         wdata_d = wdata1;
         we_d    = we1;
         sb_d    = sb1;
      end
   end

   // Request registers only change on acceptance, so the memory-side outputs
   // naturally hold their last values outside ACCESS.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         lastGrant_q <= PORT_LDR;
         owner_q     <= PORT_CPU;
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         sb_q        <= 1'b0;
         rdata_q     <= '0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|gnt) begin
                  owner_q <= owner_d;
                  addr_q  <= addr_d;
                  wdata_q <= wdata_d;
                  we_q    <= we_d;
                  sb_q    <= sb_d;
                  busy_q  <= 1'b1;
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               rdata_q   <= mem_dout;
               rvalid0_q <= (owner_q == PORT_CPU);
               rvalid1_q <= (owner_q == PORT_LDR);
               state_q   <= RESP;
            end
            RESP: begin
               rvalid0_q   <= 1'b0;
               rvalid1_q   <= 1'b0;
               lastGrant_q <= owner_q;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
            default: begin
               rvalid0_q <= 1'b0;
               rvalid1_q <= 1'b0;
               busy_q    <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   assign mem_addr = addr_q;
   assign mem_din  = wdata_q;
   assign mem_sb   = sb_q;
   assign mem_wren = we_q && (state_q == ACCESS);
   assign rdata    = rdata_q;
   assign rvalid0  = rvalid0_q;
   assign rvalid1  = rvalid1_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter + dm_4k: drivers push expected responses from a byte
// level memory model, a negedge monitor checks handshakes and responses.
module tb_dm_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid0, ready0, we0, sb0, rvalid0;
   logic        valid1, ready1, we1, sb1, rvalid1;
   logic [11:0] addr0, addr1, mem_addr;
   logic [31:0] wdata0, wdata1, rdata, mem_din, mem_dout;
   logic        busy, mem_wren, mem_sb;

   always #5 clk = ~clk;

   dm_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .valid0(valid0), .ready0(ready0), .addr0(addr0), .wdata0(wdata0),
      .we0(we0), .sb0(sb0), .rvalid0(rvalid0),
      .valid1(valid1), .ready1(ready1), .addr1(addr1), .wdata1(wdata1),
      .we1(we1), .sb1(sb1), .rvalid1(rvalid1),
      .rdata(rdata), .busy(busy),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_wren(mem_wren),
      .mem_sb(mem_sb), .mem_dout(mem_dout)
   );

   dm_4k u_mem (
      .clk(clk), .addr(mem_addr), .din(mem_din), .WrEn(mem_wren),
      .storebyte(mem_sb), .dout(mem_dout)
   );

   typedef struct {
      bit          port;
      logic [31:0] data;
      bit          known;
      int          accCyc;
   } exp_t;

   exp_t        sbq[$];
   int          grantLog[$];
   int          accLog[$];
   logic [7:0]  refMem [0:4095];
   bit          refKnown [0:4095];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          accCyc = -10;
   bit          accWe = 1'b0;
   bit          refLast = 1'b1;
   bit          expR0, expR1, expBusy, expWren;

   always @(posedge clk) cyc++;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] refRead(input int a);
      int base = a & ~3;
      return {refMem[base+3], refMem[base+2], refMem[base+1], refMem[base]};
   endfunction

   function automatic bit refReadKnown(input int a);
      int base = a & ~3;
      return refKnown[base] && refKnown[base+1] && refKnown[base+2] && refKnown[base+3];
   endfunction

   task automatic driveBus(input bit port, input bit v, input logic [11:0] a,
                           input logic [31:0] d, input bit we, input bit sb);
      if (port) begin
         valid1 = v; addr1 = a; wdata1 = d; we1 = we; sb1 = sb;
      end else begin
         valid0 = v; addr0 = a; wdata0 = d; we0 = we; sb0 = sb;
      end
   endtask

   // Present one request; on acceptance the expected response is queued and
   // the reference memory updated. Unaccepted requests are withdrawn.
   task automatic applyStimulus(input bit port, input logic [11:0] a, input logic [31:0] d,
                                input bit we, input bit sb, input int patience, input bit mustAccept);
      bit   got = 1'b0;
      int   ai  = int'(a);
      int   base = ai & ~3;
      exp_t e;
      driveBus(port, 1'b1, a, d, we, sb);
      for (int i = 0; i < patience && !got; i++) begin
         @(negedge clk);
         if ((port ? ready1 : ready0) === 1'b1) got = 1'b1;
      end
      if (got) begin
         e.port   = port;
         e.data   = refRead(ai);
         e.known  = refReadKnown(ai);
         e.accCyc = cyc;
         sbq.push_back(e);
         grantLog.push_back(int'(port));
         accLog.push_back(cyc);
         if (we) begin
            if (sb) begin
               refMem[ai] = d[7:0];
               refKnown[ai] = 1'b1;
            end else begin
               for (int k = 0; k < 4; k++) begin
                  refMem[base+k] = d[8*k +: 8];
                  refKnown[base+k] = 1'b1;
               end
            end
         end
      end else if (mustAccept) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout port %0d: got no ready expected ready within %0d cycles", port, patience);
      end
      @(posedge clk);
      #1;
      driveBus(port, 1'b0, a, d, we, sb);
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() > 0 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (sbq.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout: got %0d pending responses expected 0", sbq.size());
         sbq.delete();
      end
   endtask

   // Monitor: expected handshakes derive from the arbitration rules (3-cycle
   // occupancy, alternate on ties); responses pop from the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         accCyc  = -10;
         refLast = 1'b1;
         sbq.delete();
      end else begin
         expR0   = (cyc > accCyc + 2) && valid0 && (!valid1 || refLast);
         expR1   = (cyc > accCyc + 2) && valid1 && (!valid0 || !refLast);
         expBusy = (cyc == accCyc + 1) || (cyc == accCyc + 2);
         expWren = (cyc == accCyc + 1) && accWe;
         checkOutput("ready0", ready0, expR0);
         checkOutput("ready1", ready1, expR1);
         checkOutput("busy", busy, expBusy);
         checkOutput("mem_wren", mem_wren, expWren);
         if (sbq.size() > 0 && sbq[0].accCyc + 2 == cyc) begin
            checkOutput("rvalid0", rvalid0, !sbq[0].port);
            checkOutput("rvalid1", rvalid1, sbq[0].port);
            if (sbq[0].known) checkOutput("rdata", rdata, sbq[0].data);
            void'(sbq.pop_front());
         end else begin
            checkOutput("rvalid0_idle", rvalid0, 1'b0);
            checkOutput("rvalid1_idle", rvalid1, 1'b0);
         end
         if (ready0 === 1'b1 || ready1 === 1'b1) begin
            accCyc  = cyc;
            accWe   = ready1 ? we1 : we0;
            refLast = ready1;
         end
      end
   end

   initial begin
      #1000000;
      errors++;
      $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int gl;
      logic [31:0] d;
      for (int i = 0; i < 4096; i++) refKnown[i] = 1'b0;
      driveBus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      driveBus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      rst = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_ready0", ready0, 0);
      checkOutput("reset_ready1", ready1, 0);
      checkOutput("reset_rvalid0", rvalid0, 0);
      checkOutput("reset_rvalid1", rvalid1, 0);
      checkOutput("reset_rdata", rdata, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_mem_addr", mem_addr, 0);
      checkOutput("reset_mem_din", mem_din, 0);
      checkOutput("reset_mem_wren", mem_wren, 0);
      checkOutput("reset_mem_sb", mem_sb, 0);
      rst = 1'b0;

      for (int a = 0; a <= 'h104; a += 4) begin
         d = $urandom;
         if (a == 'h100) d = 32'hDEADBEEF;
         if (a == 'h044) d = 32'hAABBCCDD;
         if (a == 'h080) d = 32'h11111111;
         applyStimulus(1'b1, 12'(a), d, 1'b1, 1'b0, 50, 1'b1);
      end
      drain();

      applyStimulus(1'b0, 12'h100, 32'h0, 1'b0, 1'b0, 50, 1'b1);
      drain();
      checkOutput("single_read", rdata, 32'hDEADBEEF);

      applyStimulus(1'b1, 12'h040, 32'h12345678, 1'b1, 1'b0, 50, 1'b1);
      applyStimulus(1'b1, 12'h040, 32'h0, 1'b0, 1'b0, 50, 1'b1);
      drain();
      checkOutput("write_then_read", rdata, 32'h12345678);

      applyStimulus(1'b0, 12'h046, 32'h000000EE, 1'b1, 1'b1, 50, 1'b1);
      drain();
      checkOutput("sb_pre_write", rdata, 32'hAABBCCDD);
      applyStimulus(1'b0, 12'h044, 32'h0, 1'b0, 1'b0, 50, 1'b1);
      drain();
      checkOutput("sb_reread", rdata, 32'hAABBCCDD & 32'hFF00FFFF | 32'h00EE0000);

      gl = grantLog.size();
      fork
         for (int i = 0; i < 4; i++) applyStimulus(1'b0, 12'($urandom_range(0, 255)), 32'h0, 1'b0, 1'b0, 50, 1'b1);
         for (int i = 0; i < 4; i++) applyStimulus(1'b1, 12'($urandom_range(0, 255)), 32'h0, 1'b0, 1'b0, 50, 1'b1);
      join
      drain();
      for (int i = gl + 1; i < gl + 8; i++) begin
         checkOutput("contention_alternate", (grantLog[i] != grantLog[i-1]), 1);
         checkOutput("contention_spacing", accLog[i] - accLog[i-1], 3);
      end

      gl = accLog.size();
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 12'($urandom_range(0, 255)), 32'h0, 1'b0, 1'b0, 50, 1'b1);
      drain();
      checkOutput("b2b_spacing_1", accLog[gl+1] - accLog[gl], 3);
      checkOutput("b2b_spacing_2", accLog[gl+2] - accLog[gl+1], 3);

      driveBus(1'b0, 1'b1, 12'h080, 32'h22222222, 1'b1, 1'b0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ready0 !== 1'b1 && n < 50);
      checkOutput("rst_test_accept", ready0, 1);
      @(posedge clk);
      #1 valid0 = 1'b0;
      #1 rst = 1'b1;
      #1;
      checkOutput("rst_mid_access_wren", mem_wren, 0);
      checkOutput("rst_mid_access_rvalid0", rvalid0, 0);
      checkOutput("rst_mid_access_busy", busy, 0);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
      gl = grantLog.size();
      fork
         applyStimulus(1'b0, 12'h080, 32'h0, 1'b0, 1'b0, 50, 1'b1);
         applyStimulus(1'b1, 12'h080, 32'h0, 1'b0, 1'b0, 50, 1'b1);
      join
      drain();
      checkOutput("post_reset_tie_port0", grantLog[gl], 0);
      checkOutput("rst_no_commit", rdata, 32'h11111111);

      fork
         for (int i = 0; i < 40; i++) begin
            bit keen = ($urandom_range(0, 3) != 0);
            applyStimulus(1'b0, 12'($urandom_range(0, 255)), $urandom, 1'($urandom), 1'($urandom),
                          keen ? 20 : int'($urandom_range(1, 3)), keen);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
         end
         for (int i = 0; i < 40; i++) begin
            bit keen = ($urandom_range(0, 3) != 0);
            applyStimulus(1'b1, 12'($urandom_range(0, 255)), $urandom, 1'($urandom), 1'($urandom),
                          keen ? 20 : int'($urandom_range(1, 3)), keen);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
         end
      join
      drain();
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
